// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box table and round-constant helper.
package aes_pkg;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;
    typedef enum logic [1:0] {IDLE, EXPAND, READY} key_sched_state_t;

    localparam int NR = 14;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // rcon(i) for i = 1..7 is 2^(i-1); AES-256 never needs more
    function automatic logic [7:0] rcon(input logic [2:0] i);
        return 8'h01 << (i - 3'd1);
    endfunction
endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: key load, status and round-key read bundle.
interface aes_key_sched_ctrl_if;
    import aes_pkg::*;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic         zeroize;
    logic         busy;
    logic         keys_ready;
    logic [4:0]   rk_count;
    logic         rd_en;
    logic [3:0]   rd_idx;
    rkey_t        rd_data;
    logic         rd_valid;

    modport master (
        output key_valid, key_in, zeroize, rd_en, rd_idx,
        input  key_ready, busy, keys_ready, rk_count, rd_data, rd_valid
    );
    modport slave (
        input  key_valid, key_in, zeroize, rd_en, rd_idx,
        output key_ready, busy, keys_ready, rk_count, rd_data, rd_valid
    );
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w,
    output word_t s
);
    assign s = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-256 key expansion, one round key per cycle,
// with a clearable 15-entry round-key file and a registered read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    aes_key_sched_ctrl_if.slave bus
);
    key_sched_state_t state;
    logic [3:0] rnd;
    logic [4:0] rk_count;
    logic       busy, keys_ready, rd_valid, accept, rd_hit;
    rkey_t      rk [NR+1];
    rkey_t      rd_data, prev2, next_rk;
    word_t      b3, sw_in, sw_out, t, n0, n1, n2, n3;

    assign bus.key_ready  = (state != EXPAND) && !bus.zeroize;
    assign bus.busy       = busy;
    assign bus.keys_ready = keys_ready;
    assign bus.rk_count   = rk_count;
    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = rd_valid;

    assign accept = bus.key_valid && bus.key_ready;
    assign rd_hit = bus.rd_en && ({1'b0, bus.rd_idx} < rk_count);

    // Even rounds apply RotWord + rcon, odd rounds SubWord only
    assign prev2 = rk[rnd - 4'd2];
    assign b3    = rk[rnd - 4'd1][31:0];
    assign sw_in = rnd[0] ? b3 : {b3[23:0], b3[31:24]};

    aes_sub_word u_sub_word (.w(sw_in), .s(sw_out));

    assign t       = rnd[0] ? sw_out : sw_out ^ {rcon(rnd[3:1]), 24'h0};
    assign n0      = prev2[127:96] ^ t;
    assign n1      = prev2[95:64] ^ n0;
    assign n2      = prev2[63:32] ^ n1;
    assign n3      = prev2[31:0] ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rnd        <= '0;
            rk_count   <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else if (bus.zeroize) begin
            state      <= IDLE;
            rnd        <= '0;
            rk_count   <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            if (accept) begin
                rk[0]      <= bus.key_in[255:128];
                rk[1]      <= bus.key_in[127:0];
                rk_count   <= 5'd2;
                rnd        <= 4'd2;
                state      <= EXPAND;
                busy       <= 1'b1;
                keys_ready <= 1'b0;
            end else if (state == EXPAND) begin
                rk[rnd]  <= next_rk;
                rk_count <= {1'b0, rnd} + 5'd1;
                rnd      <= rnd + 4'd1;
                if (rnd == 4'(NR)) begin
                    state      <= READY;
                    busy       <= 1'b0;
                    keys_ready <= 1'b1;
                end
            end
            // Validity uses rk_count from before this edge's write
            rd_valid <= rd_hit;
            rd_data  <= rd_hit ? rk[bus.rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed vector bench for the AES-256 key scheduler,
// FIPS-197 known answers plus a word-wise reference expansion.
module tb_aes_key_sched_ctrl;
    import aes_pkg::*;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [255:0] key;
        rkey_t        rk2;
        rkey_t        rk14;
    } key_vec_t;

    typedef struct {
        logic [3:0] idx;
        logic       exp_valid;
        rkey_t      exp_data;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;
    rkey_t    m_rk [15];
    key_vec_t kv [2];
    rd_vec_t  rv [16];

    always #5 clk = ~clk;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx);
        bus.rd_en  = 1'b1;
        bus.rd_idx = idx;
        step;
        bus.rd_en  = 1'b0;
    endtask

    task automatic load(input logic [255:0] k);
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        step;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_keys(output int cyc);
        cyc = 0;
        while (!bus.keys_ready && cyc < 40) begin
            step;
            cyc++;
        end
    endtask

    function automatic word_t sub(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Reference: FIPS-197 word recurrence w[i] = w[i-8] ^ f(w[i-1])
    task automatic expand_model(input logic [255:0] k);
        word_t      w [60];
        word_t      tmp;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = rc << 1;
            end else if (i % 8 == 4) begin
                tmp = sub(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        kv[0] = '{KEY_C3, 128'ha573c29fa176c498a97fce93a572c09c, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        kv[1] = '{KEY_A3, 128'h9ba354118e6925afa51a8b5f2067fcde, 128'hfe4890d1e6188d0b046df344706c631e};
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.zeroize   = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = '0;

        repeat (2) step;
        rst_n = 1'b1;
        #1;
        chk("rst_key_ready", bus.key_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_keys_ready", bus.keys_ready, 1'b0);
        chk("rst_rk_count", bus.rk_count, 5'd0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_data", bus.rd_data, '0);

        // Load from IDLE, then re-key from READY; refuse a key mid-EXPAND
        for (int k = 0; k < 2; k++) begin
            expand_model(kv[k].key);
            load(kv[k].key);
            chk("accept_keys_ready_low", bus.keys_ready, 1'b0);
            chk("accept_busy", bus.busy, 1'b1);
            chk("accept_rk_count", bus.rk_count, 5'd2);
            n = 0;
            while (!bus.keys_ready && n < 40) begin
                if (n == 3) begin
                    bus.key_in    = ~kv[k].key;
                    bus.key_valid = 1'b1;
                    #0;
                    chk("expand_key_ready", bus.key_ready, 1'b0);
                end
                step;
                bus.key_valid = 1'b0;
                n++;
            end
            chk("latency", n, 13);
            chk("done_rk_count", bus.rk_count, 5'd15);
            chk("done_busy", bus.busy, 1'b0);
            chk("done_key_ready", bus.key_ready, 1'b1);
            rd(4'd2);
            chk("rk2_known", bus.rd_data, kv[k].rk2);
            rd(4'd14);
            chk("rk14_known", bus.rd_data, kv[k].rk14);
            rd(4'd7);
            chk("rk7_model", bus.rd_data, m_rk[7]);
        end

        // Back-to-back pipelined reads of the A.3 schedule plus one out-of-range index
        for (int i = 0; i < 16; i++) rv[i] = '{4'(i), i < 15, (i < 15) ? m_rk[i] : '0};
        for (int i = 0; i < 16; i++) begin
            rd(rv[i].idx);
            chk($sformatf("tbl_valid[%0d]", i), bus.rd_valid, rv[i].exp_valid);
            chk($sformatf("tbl_data[%0d]", i), bus.rd_data, rv[i].exp_data);
        end

        // Read of the key being written this cycle is invalid, valid one cycle later
        expand_model(KEY_C3);
        load(KEY_C3);
        n = 0;
        while (bus.rk_count != 5'd5 && n < 20) begin
            step;
            n++;
        end
        chk("rk_count_5", bus.rk_count, 5'd5);
        rd(4'd5);
        chk("inflight_valid", bus.rd_valid, 1'b0);
        chk("inflight_data", bus.rd_data, '0);
        rd(4'd5);
        chk("later_valid", bus.rd_valid, 1'b1);
        chk("later_data", bus.rd_data, m_rk[5]);
        rd(4'd15);
        chk("idx15_valid", bus.rd_valid, 1'b0);
        chk("idx15_data", bus.rd_data, '0);
        wait_keys(n);
        chk("expand_done", bus.keys_ready, 1'b1);

        // Zeroize at rnd = 7 with a competing key offer
        load(KEY_A3);
        n = 0;
        while (bus.rk_count != 5'd7 && n < 20) begin
            step;
            n++;
        end
        chk("rk_count_7", bus.rk_count, 5'd7);
        bus.zeroize   = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_in    = KEY_C3;
        bus.rd_en     = 1'b1;
        bus.rd_idx    = 4'd0;
        #1;
        chk("zero_key_ready", bus.key_ready, 1'b0);
        step;
        bus.zeroize   = 1'b0;
        bus.key_valid = 1'b0;
        bus.rd_en     = 1'b0;
        #1;
        chk("zero_rd_valid", bus.rd_valid, 1'b0);
        chk("zero_key_ready_back", bus.key_ready, 1'b1);
        chk("zero_busy", bus.busy, 1'b0);
        chk("zero_rk_count", bus.rk_count, 5'd0);
        chk("zero_keys_ready", bus.keys_ready, 1'b0);
        for (int i = 0; i < 15; i++) begin
            rd(4'(i));
            chk($sformatf("zero_valid[%0d]", i), bus.rd_valid, 1'b0);
            chk($sformatf("zero_data[%0d]", i), bus.rd_data, '0);
        end

        // Asynchronous reset mid-EXPAND, then a clean reload
        load(KEY_C3);
        repeat (5) step;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_rk_count", bus.rk_count, 5'd0);
        chk("arst_keys_ready", bus.keys_ready, 1'b0);
        chk("arst_key_ready", bus.key_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        expand_model(KEY_A3);
        load(KEY_A3);
        wait_keys(n);
        chk("arst_latency", n, 13);
        rd(4'd14);
        chk("arst_rk14", bus.rd_data, kv[1].rk14);
        rd(4'd9);
        chk("arst_rk9_model", bus.rd_data, m_rk[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
